// File: rtl/sos_req_sched_pkg.sv
// Shared definitions for the sultans_of_swing request scheduler:
// FSM state encodings, default data width and the reset-active level.
package sos_req_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int   DW_DEFAULT = 4;
  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/sos_req_sched_if.sv
// Request, datapath and response signals of the scheduler, bundled with
// modports: master is the requester/datapath/consumer side, slave the scheduler.
interface sos_req_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int DW  = 4
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload until that edge.
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*DW-1:0] req_c;

  logic [DW-1:0]   dp_a;
  logic [DW-1:0]   dp_b;
  logic [DW-1:0]   dp_c;
  logic [DW-1:0]   dp_a_res;
  logic [DW-1:0]   dp_b_res;
  logic [DW-1:0]   dp_and_res;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_a;
  logic [DW-1:0]   rsp_b;
  logic [DW-1:0]   rsp_and;

  modport master (
    output req_valid, req_a, req_b, req_c,
    output dp_a_res, dp_b_res, dp_and_res,
    output rsp_ready,
    input  req_ready, dp_a, dp_b, dp_c,
    input  rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c,
    input  dp_a_res, dp_b_res, dp_and_res,
    input  rsp_ready,
    output req_ready, dp_a, dp_b, dp_c,
    output rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and
  );

endinterface

// File: rtl/sos_req_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from N-1 back to 0.
module sos_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr is always < N, so a single subtraction gives the wrap
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[IW'(idx)]) begin
        any_grant        = 1'b1;
        grant_idx        = IDW'(idx);
        grant[IW'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sos_req_sched.sv
// Shares one sultans_of_swing datapath among N requesters: round-robin grant,
// hold operands for DP_LAT cycles, then return the results tagged with the ID.
module sos_req_sched
  import sos_req_sched_pkg::*;
#(
  parameter int N      = 4,
  parameter int IDW    = 2,
  parameter int DP_LAT = 2,
  parameter int DW     = DW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  sos_req_sched_if.slave      bus,
  output logic                busy,
  output state_t              state_dbg
);

  localparam int CW = $clog2(DP_LAT + 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, id_q, g_idx, rr_next;
  logic [N-1:0]   grant;
  logic           any_grant;
  logic [CW-1:0]  cnt_q;
  logic           take, capture, release_rsp;
  logic [DW-1:0]  a_sel, b_sel, c_sel;
  logic [DW-1:0]  dp_a_q, dp_b_q, dp_c_q;
  logic [DW-1:0]  rsp_a_q, rsp_b_q, rsp_and_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_valid_q;

  sos_rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (g_idx),
    .any_grant (any_grant)
  );

  assign rr_next = (g_idx == IDW'(N - 1)) ? '0 : g_idx + IDW'(1);

  // One-hot operand mux driven by the arbiter grant
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | bus.req_a[i*DW +: DW];
        b_sel = b_sel | bus.req_b[i*DW +: DW];
        c_sel = c_sel | bus.req_c[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) state_q <= ST_IDLE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    take          = 1'b0;
    capture       = 1'b0;
    release_rsp   = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while reset is held so no requester sees a handshake
        if (any_grant && (reset != RST_ACTIVE)) begin
          bus.req_ready = grant;
          take          = 1'b1;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_c_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_and_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (take) begin
        dp_a_q   <= a_sel;
        dp_b_q   <= b_sel;
        dp_c_q   <= c_sel;
        id_q     <= g_idx;
        rr_ptr_q <= rr_next;
        cnt_q    <= CW'(DP_LAT);
      end
      if (state_q == ST_WAIT) cnt_q <= cnt_q - CW'(1);
      if (capture) begin
        rsp_a_q     <= bus.dp_a_res;
        rsp_b_q     <= bus.dp_b_res;
        rsp_and_q   <= bus.dp_and_res;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
      // Result data is kept after the handshake; only valid drops
      if (release_rsp) rsp_valid_q <= 1'b0;
    end
  end

  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_c      = dp_c_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;
  assign bus.rsp_and   = rsp_and_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sos_req_sched.sv
// Directed bench for sos_req_sched with a datapath stub whose results
// (A, B, A&B&C) settle within two cycles of stable operands.
module tb_sos_req_sched;
  import sos_req_sched_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 4;
  localparam int LAT = 2;
  localparam int RW  = IDW + 3*DW;

  logic   clk = 1'b0;
  logic   reset;
  logic   busy;
  state_t state_dbg;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  logic [RW-1:0] exp_q[$];

  sos_req_sched_if #(.N(N), .IDW(IDW), .DW(DW)) bus ();

  sos_req_sched #(.N(N), .IDW(IDW), .DP_LAT(LAT), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // datapath stub: one register stage, settled before the capture edge
  always @(posedge clk) begin
    bus.dp_a_res   <= bus.dp_a;
    bus.dp_b_res   <= bus.dp_b;
    bus.dp_and_res <= bus.dp_a & bus.dp_b & bus.dp_c;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        chk("rsp_word", 32'({bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_and}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_c[i*DW +: DW] = c;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c);
    exp_q.push_back({IDW'(id), a, b, a & b & c});
  endtask

  task automatic wait_grant(input int budget, output int g);
    g = -1;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (bus.req_ready != '0) begin
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
        return;
      end
      tick();
    end
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [DW-1:0] ta[N] = '{4'h1, 4'h4, 4'h7, 4'hA};
  logic [DW-1:0] tb[N] = '{4'hF, 4'hE, 4'h3, 4'hC};
  logic [DW-1:0] tc[N] = '{4'h9, 4'hF, 4'h6, 4'h5};
  int rr_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int g;
    int last;
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();

    // reset state, including no grant while reset is held
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_dp", {bus.dp_a, bus.dp_b, bus.dp_c}, 0);
    chk("rst_rsp", {bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_and}, 0);
    bus.req_valid = '0;
    reset = 1'b1;
    tick();

    // single request from requester 0
    set_ops(0, 4'b1011, 4'b0110, 4'b0101);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    push_exp(0, 4'b1011, 4'b0110, 4'b0101);
    #1;
    chk("t1_ready_low", bus.req_ready, 0);
    chk("t1_dp", {bus.dp_a, bus.dp_b, bus.dp_c}, 12'b1011_0110_0101);
    chk("t1_busy", busy, 1);
    chk("t1_state", state_dbg, ST_WAIT);
    chk("t1_early0", bus.rsp_valid, 0);
    tick();
    chk("t1_early1", bus.rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp", {bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_and}, 14'b00_1011_0110_0000);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_rsp_drop", bus.rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_rsp_keep", bus.rsp_a, 4'b1011);
    bus.rsp_ready = 1'b0;

    // round robin with all requesters valid and consumer always ready
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, ta[i], tb[i], tc[i]);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, g);
      chk("rr_grant", g, rr_order[k]);
      if (k > 0) chk("rr_interval", cyc - last, LAT + 2);
      last = cyc;
      push_exp(rr_order[k], ta[rr_order[k]], tb[rr_order[k]], tc[rr_order[k]]);
      tick();
    end
    bus.req_valid = '0;
    drain();

    // backpressure: response held, no new grant until RESP exits
    set_ops(2, 4'b1111, 4'b1101, 4'b1111);
    bus.req_valid = 4'b0100;
    wait_grant(10, g);
    chk("bp_grant", g, 2);
    tick();
    bus.req_valid = '0;
    push_exp(2, 4'b1111, 4'b1101, 4'b1111);
    for (int n = 0; n < 10; n++) begin
      if (bus.rsp_valid) break;
      tick();
    end
    set_ops(0, 4'h3, 4'h5, 4'h6);
    bus.req_valid = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_and", bus.rsp_and, 4'b1101);
      chk("bp_id", bus.rsp_id, 2);
      chk("bp_busy", busy, 1);
      chk("bp_no_grant", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_resume", bus.req_ready, 4'b0001);
    chk("bp_rsp_drop", bus.rsp_valid, 0);
    tick();
    bus.req_valid = '0;
    push_exp(0, 4'h3, 4'h5, 4'h6);
    drain();

    // move rr_ptr to 3 via requester 2
    set_ops(2, 4'h8, 4'hC, 4'hE);
    bus.req_valid = 4'b0100;
    wait_grant(10, g);
    chk("pre_wrap_grant", g, 2);
    tick();
    bus.req_valid = '0;
    push_exp(2, 4'h8, 4'hC, 4'hE);
    drain();

    // wrap priority: pointer at 3 with requesters 1 and 3 valid
    set_ops(1, 4'h6, 4'h7, 4'hE);
    set_ops(3, 4'h9, 4'hB, 4'hD);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    wait_grant(10, g);
    chk("wrap_first", g, 3);
    tick();
    bus.req_valid = 4'b0010;
    push_exp(3, 4'h9, 4'hB, 4'hD);
    wait_grant(20, g);
    chk("wrap_second", g, 1);
    tick();
    bus.req_valid = '0;
    push_exp(1, 4'h6, 4'h7, 4'hE);
    drain();

    // async reset in WAIT drops the transaction and the pointer
    set_ops(2, 4'h1, 4'h1, 4'h1);
    bus.req_valid = 4'b0100;
    wait_grant(10, g);
    chk("ar_grant", g, 2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("ar_in_wait", state_dbg, ST_WAIT);
    reset = 1'b0;
    #1;
    chk("ar_rsp_valid", bus.rsp_valid, 0);
    chk("ar_dp", {bus.dp_a, bus.dp_b, bus.dp_c}, 0);
    chk("ar_busy", busy, 0);
    tick();
    reset = 1'b1;
    set_ops(1, 4'b0101, 4'b1010, 4'b1100);
    set_ops(3, 4'hF, 4'hF, 4'hF);
    bus.req_valid = 4'b1010;
    wait_grant(10, g);
    chk("ar_first", g, 1);
    tick();
    bus.req_valid = '0;
    push_exp(1, 4'b0101, 4'b1010, 4'b1100);
    drain();
    chk("ar_rsp_id", bus.rsp_id, 1);
    chk("ar_rsp_and", bus.rsp_and, 4'b0000);

    // idle hold: nothing requested for 10 cycles
    for (int n = 0; n < 10; n++) begin
      chk("idle_dp", {bus.dp_a, bus.dp_b, bus.dp_c}, 12'b0101_1010_1100);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
      chk("idle_ready", bus.req_ready, 0);
      tick();
    end
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
